// File: rtl/axi4_lite_read_master_arbiter_if.sv
// Bundle of all non-clock signals of the shared AXI4-Lite read master arbiter.
//   req_*   : local requester side (flattened per-requester vectors)
//   rsp_*   : per-requester response side (one-hot valid, shared data/resp)
//   ar*/r*  : AXI4-Lite AR and R channels towards the slave
// modport master : the arbiter (drives AR, rready, req_ready and rsp_*)
// modport slave  : the environment (requesters plus the AXI slave)
interface axi4_lite_read_master_arbiter_if #(
    parameter int unsigned NO_OF_REQ     = 2,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);
    logic [NO_OF_REQ-1:0]               req_valid;
    logic [NO_OF_REQ*ADDRESS_WIDTH-1:0] req_addr;
    logic [NO_OF_REQ*3-1:0]             req_prot;
    logic [NO_OF_REQ-1:0]               req_ready;
    logic [NO_OF_REQ-1:0]               rsp_valid;
    logic [NO_OF_REQ-1:0]               rsp_ready;
    logic [DATA_WIDTH-1:0]              rsp_data;
    logic [1:0]                         rsp_resp;
    logic [ADDRESS_WIDTH-1:0]           araddr;
    logic [2:0]                         arprot;
    logic                               arvalid;
    logic                               arready;
    logic [DATA_WIDTH-1:0]              rdata;
    logic [1:0]                         rresp;
    logic                               rvalid;
    logic                               rready;

    modport master (
        input  req_valid, req_addr, req_prot, rsp_ready, arready, rdata, rresp, rvalid,
        output req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arprot, arvalid, rready
    );

    modport slave (
        output req_valid, req_addr, req_prot, rsp_ready, arready, rdata, rresp, rvalid,
        input  req_ready, rsp_valid, rsp_data, rsp_resp, araddr, arprot, arvalid, rready
    );
endinterface

// File: rtl/axi4_lite_read_master_arbiter.sv
// Shares one AXI4-Lite read master port among NO_OF_REQ requesters.
// Round-robin arbitration, at most MAX_OUTSTANDING accepted-but-unanswered reads,
// in-order response routing via a tag FIFO, and local DECERR for addresses outside
// [MIN_ADDRESS, MAX_ADDRESS] (those never reach the bus).
// Ports:
//   aclk    : clock
//   aresetn : asynchronous active-low reset
//   bus     : request/response/AR/R signals (see axi4_lite_read_master_arbiter_if)
module axi4_lite_read_master_arbiter #(
    parameter int unsigned              NO_OF_REQ       = 2,
    parameter int unsigned              ADDRESS_WIDTH   = 32,
    parameter int unsigned              DATA_WIDTH      = 32,
    parameter int unsigned              MAX_OUTSTANDING = 10,
    parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS     = 'h01,
    parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS     = 'hff
) (
    input logic                             aclk,
    input logic                             aresetn,
    axi4_lite_read_master_arbiter_if.master bus
);

    localparam int unsigned IDX_W = (NO_OF_REQ > 1) ? $clog2(NO_OF_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned TAG_W = IDX_W + 1;

    localparam logic [0:0] AR_IDLE  = 1'b0;
    localparam logic [0:0] AR_VALID = 1'b1;

    logic [0:0]               ar_state_q, ar_state_d;
    logic [ADDRESS_WIDTH-1:0] araddr_q, araddr_d;
    logic [2:0]               arprot_q, arprot_d;
    logic [IDX_W-1:0]         rr_q, rr_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
    logic [TAG_W-1:0]         tag_mem_q [MAX_OUTSTANDING];

    logic                     gnt_found;
    logic [IDX_W-1:0]         gnt_idx;
    logic [IDX_W-1:0]         cand_idx;
    int unsigned              cand;
    logic                     grant_ok;
    logic                     accept;
    logic [ADDRESS_WIDTH-1:0] gnt_addr;
    logic [2:0]               gnt_prot;
    logic                     local_err;
    logic [NO_OF_REQ-1:0]     req_ready;

    logic [TAG_W-1:0]         head_tag;
    logic [IDX_W-1:0]         head_idx;
    logic                     head_err;
    logic                     pop;
    logic [NO_OF_REQ-1:0]     rsp_valid;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic [1:0]               rsp_resp;
    logic                     rready;

    // Round-robin search starting at rr_q.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NO_OF_REQ; k++) begin
            cand     = (32'(rr_q) + k) % NO_OF_REQ;
            cand_idx = IDX_W'(cand);
            if (!gnt_found && bus.req_valid[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // A slot freed by a same-cycle pop is deliberately not reused (no bypass).
    // aresetn gating keeps req_ready low while reset is asserted.
    assign grant_ok  = (count_q < CNT_W'(MAX_OUTSTANDING)) &&
                       ((ar_state_q == AR_IDLE) || bus.arready) && aresetn;
    assign accept    = gnt_found && grant_ok;
    assign gnt_addr  = bus.req_addr[gnt_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign gnt_prot  = bus.req_prot[gnt_idx*3 +: 3];
    assign local_err = (gnt_addr < MIN_ADDRESS) || (gnt_addr > MAX_ADDRESS);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            if (32'(gnt_idx) == NO_OF_REQ - 1) begin
                rr_d = '0;
            end else begin
                rr_d = gnt_idx + 1'b1;
            end
        end
    end

    // AR stage: a new in-range acceptance may only happen while idle or on the
    // arready edge, so overwriting the address register here is always safe.
    always_comb begin
        ar_state_d = ar_state_q;
        araddr_d   = araddr_q;
        arprot_d   = arprot_q;
        if (accept && !local_err) begin
            ar_state_d = AR_VALID;
            araddr_d   = gnt_addr;
            arprot_d   = gnt_prot;
        end else if ((ar_state_q == AR_VALID) && bus.arready) begin
            ar_state_d = AR_IDLE;
        end
    end

    // Response routing from the head tag; tags leave in acceptance order.
    assign head_tag = tag_mem_q[rd_ptr_q];
    assign head_idx = head_tag[TAG_W-1:1];
    assign head_err = head_tag[0];

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        rsp_resp  = '0;
        rready    = 1'b0;
        pop       = 1'b0;
        if (count_q != '0) begin
            if (head_err) begin
                // Local DECERR: bus R stays stalled until this one is consumed.
                rsp_valid[head_idx] = 1'b1;
                rsp_resp            = 2'b11;
                pop                 = bus.rsp_ready[head_idx];
            end else begin
                rsp_valid[head_idx] = bus.rvalid;
                rready              = bus.rsp_ready[head_idx];
                if (bus.rvalid) begin
                    rsp_data = bus.rdata;
                    rsp_resp = bus.rresp;
                end
                pop = bus.rvalid && bus.rsp_ready[head_idx];
            end
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!accept && pop) begin
            count_d = count_q - 1'b1;
        end
        if (accept) begin
            wr_ptr_d = (32'(wr_ptr_q) == MAX_OUTSTANDING - 1) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (32'(rd_ptr_q) == MAX_OUTSTANDING - 1) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_state_q <= AR_IDLE;
            araddr_q   <= '0;
            arprot_q   <= '0;
            rr_q       <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            araddr_q   <= araddr_d;
            arprot_q   <= arprot_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Tag storage needs no reset: validity is tracked by the pointers and count.
    always_ff @(posedge aclk) begin
        if (accept) begin
            tag_mem_q[wr_ptr_q] <= {gnt_idx, local_err};
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = rsp_data;
    assign bus.rsp_resp  = rsp_resp;
    assign bus.rready    = rready;
    assign bus.arvalid   = (ar_state_q == AR_VALID);
    assign bus.araddr    = araddr_q;
    assign bus.arprot    = arprot_q;

endmodule

// File: tb/tb_axi4_lite_read_master_arbiter.sv
// Scoreboard bench for axi4_lite_read_master_arbiter (2 requesters, window 'h01..'hff,
// 10 outstanding). A reference model at the transaction level predicts grants, AR
// contents and the in-order response stream; a slave model answers ARs in order.
module tb_axi4_lite_read_master_arbiter;

    localparam int unsigned MAXO = 10;

    typedef struct packed {
        logic [0:0]  idx;
        logic        err;
        logic [31:0] addr;
    } exp_t;

    logic aclk;
    logic aresetn;

    axi4_lite_read_master_arbiter_if #(
        .NO_OF_REQ(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32)
    ) bus ();

    axi4_lite_read_master_arbiter #(
        .NO_OF_REQ(2), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO),
        .MIN_ADDRESS(32'h01), .MAX_ADDRESS(32'hff)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks;
    int errors;
    int dut_acc;
    int dut_ar;
    int ar_rate;
    int r_rate;
    int rr;
    logic r_busy;

    exp_t        exp_q[$];    // every accepted request, in acceptance order
    logic [34:0] ar_q[$];     // {prot, addr} of in-range requests awaiting AR handshake
    logic [31:0] slave_q[$];  // addresses the slave has accepted, awaiting R

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] a);
        if (a == 32'h10) return 32'hCAFE_F00D;
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    function automatic logic [1:0] resp_for(input logic [31:0] a);
        return 2'(a % 32'd3);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(7))
            0:       return 32'h0;
            1:       return 32'h100 + $urandom_range(255);
            2:       return 32'hff;
            3:       return 32'h1;
            4:       return $urandom;
            default: return 32'($urandom_range(255, 1));
        endcase
    endfunction

    function automatic logic [31:0] legal_addr();
        return 32'($urandom_range(255, 1));
    endfunction

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, bus.req_ready, 0);
        check({tag, "_arvalid"}, bus.arvalid, 0);
        check({tag, "_araddr"}, bus.araddr, 0);
        check({tag, "_arprot"}, bus.arprot, 0);
        check({tag, "_rready"}, bus.rready, 0);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_data"}, bus.rsp_data, 0);
        check({tag, "_rsp_resp"}, bus.rsp_resp, 0);
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        ar_rate = 100;
        r_rate = 100;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycle();
        repeat (2) cycle();
        check("drain_slave_empty", 64'(slave_q.size()), 0);
        check("drain_idle", {bus.arvalid, bus.rsp_valid}, 0);
    endtask

    // Slave model: random arready, in-order R with rvalid held until handshake.
    always @(posedge aclk) begin
        #1;
        if (!aresetn) begin
            bus.arready = 1'b0;
            bus.rvalid = 1'b0;
        end else begin
            bus.arready = ($urandom_range(99) < ar_rate);
            if (slave_q.size() != 0 && (r_busy || $urandom_range(99) < r_rate)) begin
                r_busy = 1'b1;
                bus.rvalid = 1'b1;
                bus.rdata = data_for(slave_q[0]);
                bus.rresp = resp_for(slave_q[0]);
            end else begin
                bus.rvalid = 1'b0;
                bus.rdata = $urandom;
                bus.rresp = 2'($urandom);
            end
        end
    end

    // Monitor / reference model, sampled at the falling edge.
    logic       can_acc;
    logic       found;
    logic [1:0] exp_gnt;
    logic [1:0] exp_rv;
    logic       exp_rr;
    logic       mpop;
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    exp_t       hd;
    int         j;
    int         jsel;
    logic [31:0] a;
    logic [2:0] pr;

    always @(negedge aclk) begin
        if (aresetn) begin
            // AR channel
            check("arvalid", bus.arvalid, ar_q.size() != 0);
            if (ar_q.size() != 0 && bus.arvalid)
                check("ar_addr_prot", {29'b0, bus.arprot, bus.araddr}, {29'b0, ar_q[0]});

            // Grant prediction
            can_acc = (exp_q.size() < MAXO) && (ar_q.size() == 0 || bus.arready);
            exp_gnt = '0;
            found = 1'b0;
            jsel = 0;
            for (int k = 0; k < 2; k++) begin
                j = (rr + k) % 2;
                if (can_acc && !found && bus.req_valid[j[0]]) begin
                    found = 1'b1;
                    jsel = j;
                    exp_gnt[j[0]] = 1'b1;
                end
            end
            check("req_ready", bus.req_ready, exp_gnt);

            // Response prediction from the oldest outstanding request
            exp_rv = '0;
            exp_rr = 1'b0;
            exp_d = '0;
            exp_r = '0;
            mpop = 1'b0;
            if (exp_q.size() != 0) begin
                hd = exp_q[0];
                if (hd.err) begin
                    exp_rv[hd.idx] = 1'b1;
                    exp_r = 2'b11;
                    mpop = bus.rsp_ready[hd.idx];
                end else begin
                    exp_rr = bus.rsp_ready[hd.idx];
                    if (bus.rvalid) begin
                        exp_rv[hd.idx] = 1'b1;
                        exp_d = data_for(hd.addr);
                        exp_r = resp_for(hd.addr);
                    end
                    mpop = bus.rvalid && exp_rr;
                end
            end
            check("rsp_valid", bus.rsp_valid, exp_rv);
            check("rready", bus.rready, exp_rr);
            check("rsp_resp_data", {30'b0, bus.rsp_resp, bus.rsp_data}, {30'b0, exp_r, exp_d});

            // State updates for the coming rising edge
            if ((bus.req_valid & bus.req_ready) != 0) dut_acc++;
            if (bus.arvalid && bus.arready) begin
                dut_ar++;
                if (ar_q.size() != 0) begin
                    slave_q.push_back(ar_q[0][31:0]);
                    void'(ar_q.pop_front());
                end
            end
            if (bus.rvalid && bus.rready && slave_q.size() != 0) begin
                void'(slave_q.pop_front());
                r_busy = 1'b0;
            end
            if (mpop) void'(exp_q.pop_front());
            if (found) begin
                a = jsel[0] ? bus.req_addr[63:32] : bus.req_addr[31:0];
                pr = jsel[0] ? bus.req_prot[5:3] : bus.req_prot[2:0];
                hd.idx = jsel[0];
                hd.err = (a < 32'h01) || (a > 32'hff);
                hd.addr = a;
                exp_q.push_back(hd);
                if (!hd.err) ar_q.push_back({pr, a});
                rr = (jsel + 1) % 2;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        dut_acc = 0;
        dut_ar = 0;
        ar_rate = 100;
        r_rate = 100;
        rr = 0;
        r_busy = 1'b0;
        aresetn = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_addr = '0;
        bus.req_prot = '0;
        bus.rsp_ready = '0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata = '0;
        bus.rresp = '0;
        #3 check_reset("init");
        cycle();
        cycle();
        aresetn = 1'b1;
        bus.req_valid = '0;

        // Single read of 'h10
        cycle();
        bus.req_valid = 2'b01;
        bus.req_addr[31:0] = 32'h10;
        bus.req_prot[2:0] = 3'b001;
        bus.rsp_ready = 2'b11;
        cycle();
        bus.req_valid = '0;
        repeat (5) cycle();

        // Local DECERR ordering with stalled responses
        drain();
        dut_ar = 0;
        bus.rsp_ready = 2'b00;
        cycle(); bus.req_valid = 2'b10; bus.req_addr[63:32] = 32'h20;
        cycle(); bus.req_valid = 2'b01; bus.req_addr[31:0] = 32'h100;
        cycle(); bus.req_valid = 2'b10; bus.req_addr[63:32] = 32'h30;
        cycle(); bus.req_valid = 2'b00;
        repeat (4) cycle();
        bus.rsp_ready = 2'b11;
        repeat (8) cycle();
        check("decerr_ar_count", dut_ar, 2);

        // Outstanding cap with no bus responses
        drain();
        r_rate = 0;
        dut_acc = 0;
        repeat (14) begin
            cycle();
            bus.req_valid = 2'b11;
            bus.req_addr = {legal_addr(), legal_addr()};
        end
        @(negedge aclk);
        #1;
        check("cap_accepted", dut_acc, MAXO);
        check("cap_ready_low", bus.req_ready, 0);
        r_rate = 100;
        repeat (6) cycle();
        drain();

        // Randomized traffic under several backpressure mixes
        for (int p = 0; p < 3; p++) begin
            ar_rate = (p == 0) ? 70 : (p == 1) ? 20 : 100;
            r_rate = (p == 0) ? 60 : (p == 1) ? 90 : 30;
            repeat (1000) begin
                cycle();
                bus.req_valid = 2'($urandom);
                bus.req_addr = {rand_addr(), rand_addr()};
                bus.req_prot = 6'($urandom);
                bus.rsp_ready = {($urandom_range(3) != 0), ($urandom_range(3) != 0)};
            end
            drain();
        end

        // Reset with three reads outstanding
        r_rate = 0;
        ar_rate = 100;
        repeat (3) begin
            cycle();
            bus.req_valid = 2'b01;
            bus.req_addr[31:0] = legal_addr();
        end
        cycle();
        bus.req_valid = 2'b11;
        #2;
        aresetn = 1'b0;
        exp_q.delete();
        ar_q.delete();
        slave_q.delete();
        rr = 0;
        r_busy = 1'b0;
        bus.rvalid = 1'b0;
        #1 check_reset("midop");
        repeat (2) cycle();
        aresetn = 1'b1;
        @(negedge aclk);
        #1;
        check("post_reset_grant", bus.req_ready, 2'b01);
        cycle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
